// File: rtl/simple_risc_pkg.sv
// Shared constants and types for the Simple-RISC datapath.
package simple_risc_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    // Register 0 is the hardwired-zero register.
    localparam int ZERO_REG   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

endpackage

// File: rtl/reg_wr_decoder.sv
// One-hot write-enable decoder for the register file (demux direction).
// Bit ZERO_REG is always 0 so the hardwired-zero register never loads.
module reg_wr_decoder
    import simple_risc_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wr_addr,
    output logic [2**ADDR_W-1:0] wr_en
);

    localparam int R = 2 ** ADDR_W;

    logic [R-1:0] addr_hit;

    // Address match per register, one bit per destination.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_hit
            assign addr_hit[gi] = (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    // Gate the match vector with we; an unknown we falls into the else path and
    // therefore behaves as 0. The zero register is masked off last.
    always_comb begin
        wr_en = '0;
        if (we) begin
            wr_en = addr_hit;
        end
        wr_en[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/reg_file.sv
// Simple-RISC register file: 2**ADDR_W registers of N bits, one write port,
// two combinational read ports, register 0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file
    import simple_risc_pkg::*;
#(
    parameter int N      = DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [N-1:0]      rd_data_a,
    output logic [N-1:0]      rd_data_b,
    output logic [7:0]        wr_count
);

    localparam int R = 2 ** ADDR_W;

    logic [R-1:0]        wr_en;
    logic [R-1:0][N-1:0] regs_reg;
    logic [7:0]          wr_count_reg;

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][N-1:0]      rd_data;

    reg_wr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wr_decoder (
        .we      (we),
        .wr_addr (wr_addr),
        .wr_en   (wr_en)
    );

    // Register storage: cleared asynchronously, each entry loads on its one-hot
    // enable. Entry 0 is never enabled, so it holds its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_reg <= '0;
        end else begin
            for (int i = 0; i < R; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= wr_data;
                end
            end
        end
    end

    // Debug counter of accepted writes; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_reg <= '0;
        end else if (|wr_en) begin
            wr_count_reg <= wr_count_reg + 8'd1;
        end
    end

    assign rd_addr = {rd_addr_b, rd_addr_a};

    // Both read ports are identical combinational lookups.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REG_FILE_BYPASS_EN
            // Forward the write bus when this port reads the register being
            // written this cycle; suppressed in reset so reads stay 0.
            logic fwd;
            assign fwd         = rst_n & wr_en[rd_addr[gi]];
            assign rd_data[gi] = fwd ? wr_data : regs_reg[rd_addr[gi]];
`else
            assign rd_data[gi] = regs_reg[rd_addr[gi]];
`endif
        end
    endgenerate

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
    assign wr_count  = wr_count_reg;

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file. Stimulus pushes expected read
// values computed from an array model; a negedge monitor pops and compares.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd_addr_a = '0;
    logic [2:0]  rd_addr_b = '0;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [7:0]  wr_count;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          port;   // 0 = port A, 1 = port B, 2 = wr_count
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [15:0] model_regs [8];
    logic [7:0]  model_count;

    // Monitor: everything expected for this half-cycle is compared at negedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                0:       act = rd_data_a;
                1:       act = rd_data_b;
                default: act = {8'h00, wr_count};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end else begin
                $display("ok   %s = %h", e.name, act);
            end
        end
    end

    // Reference read: register 0 is zero, otherwise the stored value, or the
    // in-flight write data when forwarding is built in.
    function automatic logic [15:0] expect_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
`ifdef REG_FILE_BYPASS_EN
        if (rst_n === 1'b1 && we === 1'b1 && wr_addr != 3'd0 && a == wr_addr)
            return wr_data;
`endif
        return model_regs[a];
    endfunction

    // One clock cycle of stimulus, driven 2 time units after a rising edge.
    task automatic cycle(input logic rn, input logic w, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [2:0] ra,
                         input logic [2:0] rb, input string tag);
        exp_t e;
        rst_n = rn; we = w; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        if (rn !== 1'b1) begin
            for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
            model_count = 8'd0;
        end
        e.name = {tag, "_a"};   e.port = 0; e.exp = expect_read(ra);        sb.push_back(e);
        e.name = {tag, "_b"};   e.port = 1; e.exp = expect_read(rb);        sb.push_back(e);
        e.name = {tag, "_cnt"}; e.port = 2; e.exp = {8'h00, model_count};   sb.push_back(e);
        @(posedge clk);
        if (rn === 1'b1 && w === 1'b1 && wa != 3'd0) begin
            model_regs[wa] = wd;
            model_count    = model_count + 8'd1;
        end
        #2;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
        model_count = 8'd0;
        @(posedge clk);
        #2;

        // Reset held while a write is attempted: reset wins.
        cycle(1'b0, 1'b1, 3'd3, 16'h5555, 3'd3, 3'd0, "rst_hold");
        cycle(1'b1, 1'b1, 3'd3, 16'h00AA, 3'd3, 3'd0, "wr_r3");
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, "rd_r3");
        // Asynchronous reset mid-cycle: checked before the next rising edge.
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, "async_rst");
        cycle(1'b1, 1'b1, 3'd1, 16'h1234, 3'd1, 3'd2, "wr_r1");
        cycle(1'b1, 1'b1, 3'd2, 16'hBEEF, 3'd1, 3'd2, "wr_r2");
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, "rd_r1_r2");
        // Writes to register 0 are dropped and not counted.
        cycle(1'b1, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, "wr_r0");
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, "rd_r0");
        // Same-cycle read and write of r5.
        cycle(1'b1, 1'b1, 3'd5, 16'h0011, 3'd5, 3'd5, "wr_r5");
        cycle(1'b1, 1'b1, 3'd5, 16'h0022, 3'd5, 3'd6, "same_cyc");
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, "after_same");
        // One-hot isolation: write r7 then sweep every address on both ports.
        cycle(1'b1, 1'b1, 3'd7, 16'h7777, 3'd7, 3'd0, "wr_r7");
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "sweep");
        // Counter wrap: 257 writes to r4.
        for (int i = 0; i < 257; i++)
            cycle(1'b1, 1'b1, 3'd4, 16'($urandom), 3'd4, 3'(i), "wrap");
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd0, "wrap_end");
        // Unknown write enable must not write.
        cycle(1'b1, 1'bx, 3'd6, 16'hDEAD, 3'd6, 3'd6, "we_x");
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, "we_x_after");
        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), "rand");

        // Let the monitor drain; anything left unchecked is itself a failure.
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
